// File: rtl/lineal_norm_multicanal.sv
// rtl/lineal_norm_multicanal.sv - N-channel linearise/normalise engine on one shared shift-add multiplier; define LN_OVF_FLAG_EN for the OVF saturation flag port
module lineal_norm_multicanal #(
  parameter int N    = 2,
  parameter int W    = 32,
  parameter int FRAC = 16
) (
  input  logic           CLK,
  input  logic           RST_LN_FF,
  input  logic [N-1:0]   Begin_FSM,
  input  logic [N*W-1:0] X_IN,
  input  logic [N*W-1:0] OFFSET,
  input  logic [N*W-1:0] GAIN,
  output logic [N-1:0]   ACK,
  output logic [N*W-1:0] RESULT
`ifdef LN_OVF_FLAG_EN
  ,
  output logic [N-1:0]   OVF
`endif
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam int AW = 2 * W + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
  localparam logic [IW-1:0] PTR_INIT = IW'(N - 1);
  localparam logic signed [AW-1:0] SAT_HI = {{(W + 2){1'b0}}, {(W - 1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_LO = {{(W + 2){1'b1}}, {(W - 1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, SAT} state_t;
  state_t state, state_nxt;

  logic [N-1:0]          pending;
  logic [W-1:0]          x_lat [N];
  logic [IW-1:0]         ptr;
  logic [IW-1:0]         gidx;
  logic signed [W:0]     diff;
  logic [W-1:0]          mplier;
  logic signed [AW-1:0]  acc;
  logic [CW-1:0]         cnt;
  logic [N-1:0]          ack_r;
  logic [N*W-1:0]        result_r;

  logic                  any_pend;
  logic [IW-1:0]         gsel;
  logic [IW:0]           rr_sum;
  logic                  do_grant;
  logic                  do_mul;
  logic                  do_sat;
  logic signed [W:0]     diff_nxt;
  logic [W-1:0]          off_sel;
  logic signed [AW-1:0]  addend;
  logic signed [AW-1:0]  shifted;
  logic                  sat_hi_hit;
  logic                  sat_lo_hit;
  logic [W-1:0]          sat_val;

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RST_LN_FF) state <= IDLE;
    else           state <= state_nxt;
  end

  // FSM next state: idle until work is pending, W multiply steps, one clamp/writeback step
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_pend) state_nxt = MUL;
      MUL:     if (cnt == CNT_LAST) state_nxt = SAT;
      SAT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: datapath strobes for grant, multiply step and writeback
  always_comb begin
    do_grant = (state == IDLE) && any_pend;
    do_mul   = (state == MUL);
    do_sat   = (state == SAT);
  end

  // Round-robin search: first pending channel after the last one served, with wrap
  always_comb begin
    any_pend = 1'b0;
    gsel     = ptr;
    rr_sum   = '0;
    for (int i = 1; i <= N; i++) begin
      rr_sum = {1'b0, ptr} + (IW + 1)'(i);
      if (rr_sum >= (IW + 1)'(N)) rr_sum = rr_sum - (IW + 1)'(N);
      if (!any_pend && pending[rr_sum[IW-1:0]]) begin
        any_pend = 1'b1;
        gsel     = rr_sum[IW-1:0];
      end
    end
  end

  // Operand preparation and the current shift-add partial product
  always_comb begin
    off_sel  = OFFSET[int'(gsel) * W +: W];
    diff_nxt = $signed({x_lat[gsel][W-1], x_lat[gsel]}) - $signed({off_sel[W-1], off_sel});
    addend   = mplier[cnt] ? ($signed({{W{diff[W]}}, diff}) <<< cnt) : '0;
  end

  // Fixed-point rescale (floors toward -inf) and clamp into the W-bit signed range
  always_comb begin
    shifted    = acc >>> FRAC;
    sat_hi_hit = shifted > SAT_HI;
    sat_lo_hit = shifted < SAT_LO;
    if (sat_hi_hit)      sat_val = {1'b0, {(W - 1){1'b1}}};
    else if (sat_lo_hit) sat_val = {1'b1, {(W - 1){1'b0}}};
    else                 sat_val = shifted[W-1:0];
  end

`ifdef LN_OVF_FLAG_EN
  logic [N-1:0] ovf_r;

  // Saturation flag per channel, cleared together with ACK on an accepted start
  always_ff @(posedge CLK) begin
    if (RST_LN_FF) begin
      ovf_r <= '0;
    end else begin
      for (int k = 0; k < N; k++)
        if (Begin_FSM[k] && !pending[k]) ovf_r[k] <= 1'b0;
      if (do_sat) ovf_r[gidx] <= sat_hi_hit || sat_lo_hit;
    end
  end

  assign OVF = ovf_r;
`endif

  // Capture, grant, multiply and writeback; writeback is last so it wins on shared bits
  always_ff @(posedge CLK) begin
    if (RST_LN_FF) begin
      pending  <= '0;
      ack_r    <= '0;
      result_r <= '0;
      ptr      <= PTR_INIT;
      gidx     <= '0;
      diff     <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
      for (int k = 0; k < N; k++) x_lat[k] <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (Begin_FSM[k] && !pending[k]) begin
          x_lat[k]   <= X_IN[k * W +: W];
          pending[k] <= 1'b1;
          ack_r[k]   <= 1'b0;
        end
      end
      if (do_grant) begin
        gidx   <= gsel;
        diff   <= diff_nxt;
        mplier <= GAIN[int'(gsel) * W +: W];
        acc    <= '0;
        cnt    <= '0;
      end
      if (do_mul) begin
        acc <= acc + addend;
        cnt <= cnt + CW'(1);
      end
      if (do_sat) begin
        result_r[int'(gidx) * W +: W] <= sat_val;
        ack_r[gidx]                   <= 1'b1;
        pending[gidx]                 <= 1'b0;
        ptr                           <= gidx;
      end
    end
  end

  assign ACK    = ack_r;
  assign RESULT = result_r;

endmodule

// File: tb/tb_lineal_norm_multicanal.sv
// tb/tb_lineal_norm_multicanal.sv - randomized self-checking bench for lineal_norm_multicanal
module tb_lineal_norm_multicanal;

  localparam int N    = 2;
  localparam int W    = 32;
  localparam int FRAC = 16;
  localparam int LAT  = W + 2;

  logic           CLK = 1'b0;
  logic           RST_LN_FF;
  logic [N-1:0]   Begin_FSM;
  logic [N*W-1:0] X_IN;
  logic [N*W-1:0] OFFSET;
  logic [N*W-1:0] GAIN;
  logic [N-1:0]   ACK;
  logic [N*W-1:0] RESULT;
`ifdef LN_OVF_FLAG_EN
  logic [N-1:0]   OVF;
`endif

  int checks   = 0;
  int failures = 0;
  int last_served;

  lineal_norm_multicanal #(.N(N), .W(W), .FRAC(FRAC)) dut (
    .CLK       (CLK),
    .RST_LN_FF (RST_LN_FF),
    .Begin_FSM (Begin_FSM),
    .X_IN      (X_IN),
    .OFFSET    (OFFSET),
    .GAIN      (GAIN),
    .ACK       (ACK),
    .RESULT    (RESULT)
`ifdef LN_OVF_FLAG_EN
    ,
    .OVF       (OVF)
`endif
  );

  always #5 CLK = ~CLK;

  initial begin
    #5000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: exact wide arithmetic, floor division by 2^FRAC, then clamp
  function automatic logic [W-1:0] ref_norm(input logic [W-1:0] x, input logic [W-1:0] off,
                                            input logic [W-1:0] g, output logic sat);
    logic signed [127:0] d, p, s, hi, lo;
    d  = $signed({{(128 - W){x[W-1]}}, x}) - $signed({{(128 - W){off[W-1]}}, off});
    p  = d * $signed({{(128 - W){1'b0}}, g});
    s  = p >>> FRAC;
    hi = (128'sd1 <<< (W - 1)) - 128'sd1;
    lo = -(128'sd1 <<< (W - 1));
    sat = 1'b1;
    if (s > hi) return hi[W-1:0];
    if (s < lo) return lo[W-1:0];
    sat = 1'b0;
    return s[W-1:0];
  endfunction

  task automatic set_ch(input int k, input logic [W-1:0] x, input logic [W-1:0] o, input logic [W-1:0] g);
    X_IN[k * W +: W]   = x;
    OFFSET[k * W +: W] = o;
    GAIN[k * W +: W]   = g;
  endtask

  task automatic pulse(input logic [N-1:0] m);
    Begin_FSM = m;
    @(posedge CLK); #1;
    Begin_FSM = '0;
  endtask

  // Start the channels in mask together, expect completion in round-robin order W+2 cycles apart
  task automatic run_batch(input logic [N-1:0] mask, input string tag);
    logic [W-1:0] ex [N];
    logic         exs [N];
    int           el [N];
    int           rise [N];
    int           pos;
    int           last;
    int           c;
    pos  = 0;
    last = last_served;
    for (int k = 0; k < N; k++) begin
      ex[k]   = ref_norm(X_IN[k * W +: W], OFFSET[k * W +: W], GAIN[k * W +: W], exs[k]);
      rise[k] = -1;
      el[k]   = 0;
    end
    for (int i = 1; i <= N; i++) begin
      c = (last_served + i) % N;
      if (mask[c]) begin
        pos++;
        el[c] = pos * LAT;
        last  = c;
      end
    end
    pulse(mask);
    for (int n = 1; n <= pos * LAT + 10; n++) begin
      @(posedge CLK); #1;
      for (int k = 0; k < N; k++)
        if (mask[k] && rise[k] < 0 && ACK[k]) rise[k] = n;
    end
    for (int k = 0; k < N; k++) begin
      if (mask[k]) begin
        check($sformatf("%s_lat%0d", tag, k), 64'(rise[k]), 64'(el[k]));
        check($sformatf("%s_res%0d", tag, k), 64'(RESULT[k * W +: W]), 64'(ex[k]));
        check($sformatf("%s_held%0d", tag, k), 64'(ACK[k]), 64'd1);
`ifdef LN_OVF_FLAG_EN
        check($sformatf("%s_ovf%0d", tag, k), 64'(OVF[k]), 64'(exs[k]));
`endif
      end
    end
    last_served = last;
  endtask

  initial begin
    logic [W-1:0] e0, e1, e0b;
    logic         s0, s1, s0b;
    int           r0, r1, r2, first, other;
    bit           late;
    logic [N-1:0] m;

    RST_LN_FF = 1'b1;
    Begin_FSM = '0;
    X_IN      = '0;
    OFFSET    = '0;
    GAIN      = '0;
    repeat (2) @(posedge CLK);
    #1;
    RST_LN_FF   = 1'b0;
    last_served = N - 1;
    check("rst_ack", 64'(ACK), 64'd0);
    check("rst_result", 64'(RESULT), 64'd0);
`ifdef LN_OVF_FLAG_EN
    check("rst_ovf", 64'(OVF), 64'd0);
`endif

    // Gain and offset on ch0
    set_ch(0, 32'd1000, 32'd200, 32'h0001_8000);
    run_batch(2'b01, "gain");
    check("gain_const", 64'(RESULT[31:0]), 64'd1200);
    check("gain_ack1", 64'(ACK[1]), 64'd0);

    // Flooring on ch1
    set_ch(1, 32'hFFFF_FFFD, 32'd0, 32'h0000_8000);
    run_batch(2'b10, "floor");
    check("floor_const", 64'(RESULT[63:32]), 64'hFFFF_FFFE);
    set_ch(1, 32'hFFFF_FF9C, 32'd0, 32'h0000_8000);
    run_batch(2'b10, "floor2");
    check("floor2_const", 64'(RESULT[63:32]), 64'hFFFF_FFCE);
    check("floor_ch0_kept", 64'(RESULT[31:0]), 64'd1200);

    // Saturation both directions, started together
    set_ch(0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0002_0000);
    set_ch(1, 32'h8000_0000, 32'h0000_0001, 32'h0002_0000);
    run_batch(2'b11, "sat");
    check("sat_hi_const", 64'(RESULT[31:0]), 64'h7FFF_FFFF);
    check("sat_lo_const", 64'(RESULT[63:32]), 64'h8000_0000);

    // Simultaneous start; re-Begin of pending ch1 with a new sample must be ignored
    set_ch(0, 32'd5000, 32'hFFFF_FC18, 32'h0000_C000);
    set_ch(1, 32'hFFFF_EC78, 32'd300, 32'h0003_4000);
    e0 = ref_norm(X_IN[31:0], OFFSET[31:0], GAIN[31:0], s0);
    e1 = ref_norm(X_IN[63:32], OFFSET[63:32], GAIN[63:32], s1);
    first = (last_served + 1) % N;
    r0 = -1; r1 = -1;
    pulse(2'b11);
    for (int n = 1; n <= 2 * LAT + 10; n++) begin
      @(posedge CLK); #1;
      Begin_FSM = '0;
      if (n == 5) begin
        X_IN[63:32] = 32'd77777;
        Begin_FSM   = 2'b10;
      end
      if (r0 < 0 && ACK[0]) r0 = n;
      if (r1 < 0 && ACK[1]) r1 = n;
    end
    check("simul_lat0", 64'(r0), 64'((first == 0) ? LAT : 2 * LAT));
    check("simul_lat1", 64'(r1), 64'((first == 1) ? LAT : 2 * LAT));
    check("simul_res0", 64'(RESULT[31:0]), 64'(e0));
    check("simul_res1_ignored", 64'(RESULT[63:32]), 64'(e1));
    check("simul_held", 64'(ACK), 64'b11);
    last_served = (first == 0) ? 1 : 0;

    // Reset mid-operation drops the job
    set_ch(0, 32'd12345, 32'd45, 32'h0001_0000);
    pulse(2'b01);
    for (int n = 1; n <= 9; n++) begin
      @(posedge CLK); #1;
    end
    RST_LN_FF = 1'b1;
    @(posedge CLK); #1;
    RST_LN_FF   = 1'b0;
    last_served = N - 1;
    check("midrst_ack", 64'(ACK), 64'd0);
    check("midrst_result", 64'(RESULT), 64'd0);
    late = 1'b0;
    for (int n = 0; n < 3 * LAT; n++) begin
      @(posedge CLK); #1;
      if (ACK != '0) late = 1'b1;
    end
    check("midrst_no_late_ack", 64'(late), 64'd0);
    run_batch(2'b01, "after_rst");

    // Fairness: the first-served channel re-issues right after its ACK while the other is pending
    first = (last_served + 1) % N;
    other = 1 - first;
    set_ch(first, 32'd40000, 32'd1000, 32'h0000_4000);
    set_ch(other, 32'hFFFF_0000, 32'd16, 32'h0001_2000);
    e0 = ref_norm(X_IN[first * W +: W], OFFSET[first * W +: W], GAIN[first * W +: W], s0);
    e1 = ref_norm(X_IN[other * W +: W], OFFSET[other * W +: W], GAIN[other * W +: W], s1);
    r0 = -1; r1 = -1; r2 = -1;
    e0b = '0; s0b = 1'b0;
    pulse(2'b11);
    for (int n = 1; n <= 3 * LAT + 10; n++) begin
      @(posedge CLK); #1;
      Begin_FSM = '0;
      if (r0 >= 0 && n > r0 + 1 && r2 < 0 && ACK[first]) r2 = n;
      if (r0 < 0 && ACK[first]) begin
        r0 = n;
        check("fair_first_res", 64'(RESULT[first * W +: W]), 64'(e0));
        X_IN[first * W +: W] = 32'd90000;
        e0b = ref_norm(X_IN[first * W +: W], OFFSET[first * W +: W], GAIN[first * W +: W], s0b);
        Begin_FSM[first] = 1'b1;
      end
      if (r1 < 0 && ACK[other]) r1 = n;
    end
    check("fair_grant1", 64'(r0), 64'(LAT));
    check("fair_grant2", 64'(r1), 64'(2 * LAT));
    check("fair_grant3", 64'(r2), 64'(3 * LAT));
    check("fair_other_res", 64'(RESULT[other * W +: W]), 64'(e1));
    check("fair_reissue_res", 64'(RESULT[first * W +: W]), 64'(e0b));
    last_served = first;

    // Random batches: mixed small-range and full-range operands
    for (int it = 0; it < 10; it++) begin
      m = N'($urandom_range(1, 3));
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 1) == 0)
          set_ch(k, W'($urandom_range(0, 200000)) - 32'd100000,
                    W'($urandom_range(0, 2000)) - 32'd1000,
                    W'($urandom_range(0, 1 << 20)));
        else
          set_ch(k, W'($urandom), W'($urandom), W'($urandom));
      end
      run_batch(m, $sformatf("rnd%0d", it));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lineal_norm_multicanal.md
Name: lineal_norm_multicanal

Overview:
- N-channel fixed-point linearisation/normalisation engine: RESULT_k = sat(((X_k - OFFSET_k) * GAIN_k) >>> FRAC).
- Parametrised successor of the fixed two-channel (I/V) linealizador/normalizador.
- Channels share one iterative shift-add multiplier through a round-robin arbiter.
- Each channel keeps the existing Begin_FSM/ACK handshake toward the acquisition controller.

Parameters:
- N, 2, number of channels (ch0 = I, ch1 = V in the current system)
- W, 32, data width of X, OFFSET, GAIN, RESULT
- FRAC, 16, fractional bits of GAIN (unsigned Q(W-FRAC).FRAC)

Ports:
- CLK  in  1  system clock, all logic on rising edge
- RST_LN_FF  in  1  synchronous, active-high reset
- Begin_FSM  in  N  per-channel start strobe, sampled on CLK
- X_IN  in  N*W  packed signed samples, channel k at [k*W +: W]
- OFFSET  in  N*W  packed signed offsets, quasi-static
- GAIN  in  N*W  packed unsigned gains, quasi-static
- ACK  out  N  per-channel result-valid
- RESULT  out  N*W  packed signed results
- OVF  out  N  per-channel saturation flag (only with LN_OVF_FLAG_EN)

Behaviour:
- Reset:
  - Applies only at a CLK edge while RST_LN_FF=1.
  - Clears ACK, RESULT, OVF, pending flags, accumulator and counter.
  - FSM goes to IDLE; RR pointer goes to N-1, so ch0 has first priority.
  - Reset mid-operation drops all in-flight and pending work with no ACK.
- Capture:
  - Begin_FSM[k]=1 with pending[k]=0 and channel k not in service: X_IN[k] is latched, pending[k] is set, and ACK[k] clears on that edge.
  - Begin_FSM[k] while pending or in service is ignored; the latched sample is kept.
- FSM states: IDLE, MUL, SAT.
- IDLE:
  - If any pending flag is set, grant the first pending channel searching from pointer+1 upward, with wrap.
  - Load diff = X_lat - OFFSET_k, (W+1)-bit signed, no overflow possible.
  - Load multiplier GAIN_k, sampled at grant; clear accumulator and cnt; go to MUL.
- MUL:
  - One multiplier bit per cycle, LSB first.
  - Accumulator is signed 2W+1 bits: add diff<<cnt when the bit is 1.
  - After W cycles (cnt=W-1), go to SAT.
- SAT:
  - shifted = acc >>> FRAC (arithmetic shift, rounds toward -inf).
  - Clamp to [-2^(W-1), 2^(W-1)-1] and write RESULT_k.
  - Set ACK[k], clear pending[k], pointer = k, go to IDLE.
- Latency:
  - Begin sampled at edge t with the engine idle: ACK[k] is high after edge t+W+2 (34 cycles at W=32).
  - Each further queued channel adds W+2 cycles.
- ACK[k] stays high and RESULT_k stays stable until the next accepted Begin_FSM[k] or reset. Other channels' results are unaffected.
- Begin_FSM[k] on the same edge as SAT for channel k: SAT wins, so ACK sets and the new Begin is ignored.
- Simultaneous Begins on several channels: all are captured on the same edge and served in RR order.
- Fairness: a channel granted this round is served again only after every other pending channel.

Optional Feature:
- Macro LN_OVF_FLAG_EN.
- Defined:
  - OVF port exists.
  - OVF[k] is written in SAT: 1 if clamping occurred, else 0.
  - OVF[k] clears with ACK[k] on an accepted Begin and on reset.
- Undefined:
  - No OVF port and no flag logic.
  - Saturation behaviour is identical.

Test Plan:
- Gain and offset: N=2, W=32, FRAC=16; ch0 X=1000, OFFSET=200, GAIN=0x00018000 (1.5), single Begin -> ACK[0]=1 exactly 34 cycles later, RESULT0=1200, ACK[1]=0.
- Flooring: ch1 X=-3, OFFSET=0, GAIN=0x00008000 (0.5) -> RESULT1=0xFFFFFFFE (-2); then X=-100 -> RESULT1=-50.
- Saturation: X=0x7FFFFFFF, OFFSET=0xFFFFFFFF (-1), GAIN=0x00020000 (2.0) -> RESULT=0x7FFFFFFF, OVF=1 with macro. X=0x80000000, OFFSET=1 -> 0x80000000, OVF=1.
- Simultaneous start: Begin on ch0 and ch1 at edge t -> ACK[0] after t+34, ACK[1] after t+68, both held thereafter. Re-Begin ch1 while pending is ignored, result unchanged.
- Reset mid-operation: RST_LN_FF=1 for one edge at t+10 -> ACK=0, RESULT=0, no late ACK. A fresh Begin afterwards completes normally in 34 cycles.
- Fairness: ch0 re-issues Begin immediately after each ACK while ch1 is pending -> grants alternate ch0, ch1, ch0.
